// File: rtl/regfile_seq.sv
// Instruction sequencer for an 8 x 16-bit register file datapath.
// Accepts one instruction per start/busy handshake and emits Moore-style controls.
module regfile_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  alu_op,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GETA   = 3'd2,
    S_GETB   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRREG  = 3'd5,
    S_WRIMM  = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t      state_reg, state_next;
  logic [15:0] instr_reg;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn, legal;
  logic       write_raw, done_raw, err_raw;

  // Field decode always works from the latched copy, never the live input.
  assign opcode  = instr_reg[15:13];
  assign op      = instr_reg[12:11];
  assign rn      = instr_reg[10:8];
  assign rd      = instr_reg[7:5];
  assign rm      = instr_reg[2:0];
  assign sximm8  = {{8{instr_reg[7]}}, instr_reg[7:0]};

  assign is_movi = (opcode == OPC_MOV) && (op == 2'b10);
  assign is_movr = (opcode == OPC_MOV) && (op == 2'b00);
  assign is_alu  = (opcode == OPC_ALU);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign legal   = is_movi || is_movr || is_alu;

  // State and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
      instr_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && start) begin
        instr_reg <= instr;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT: begin
        if (start) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                 state_next = S_WRIMM;
        else if (is_movr || is_mvn)  state_next = S_GETB;
        else if (is_alu)             state_next = S_GETA;
        else                         state_next = S_WAIT;
      end
      S_GETA:  state_next = S_GETB;
      S_GETB:  state_next = S_EXEC;
      S_EXEC:  state_next = is_cmp ? S_WAIT : S_WRREG;
      S_WRREG: state_next = S_WAIT;
      S_WRIMM: state_next = S_WAIT;
      default: state_next = S_WAIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    readnum   = 3'd0;
    writenum  = 3'd0;
    write_raw = 1'b0;
    done_raw  = 1'b0;
    err_raw   = 1'b0;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    alu_op    = 2'b00;
    case (state_reg)
      S_DECODE: begin
        err_raw = !legal;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        if (is_cmp) begin
          loads    = 1'b1;
          alu_op   = 2'b01;
          done_raw = 1'b1;
        end else begin
          // MOV reg passes B through the adder with A forced to zero
          loadc  = 1'b1;
          asel   = is_movr;
          alu_op = is_movr ? 2'b00 : op;
        end
      end
      S_WRREG: begin
        writenum  = rd;
        vsel      = 2'b00;
        write_raw = 1'b1;
        done_raw  = 1'b1;
      end
      S_WRIMM: begin
        writenum  = rn;
        vsel      = 2'b01;
        write_raw = 1'b1;
        done_raw  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A reset landing on a final state abandons it: no write, no completion pulse.
  assign busy  = (state_reg != S_WAIT);
  assign write = write_raw && !reset;
  assign done  = done_raw && !reset;
  assign err   = err_raw && !reset;

endmodule
